imem_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end. Sequences the PC and issues word-address reads to a synchronous I-MEM with 1-cycle read latency. Buffers returned instructions in a small FIFO and presents them to decode over a valid/ready handshake. Also handles branch/jump redirects, and flags misaligned or out-of-range PCs in the fetched stream instead of reading memory for them.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/imem_fetch_unit.sv | 101 ++++++++++
 tb/tb_imem_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W   = 32;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic              fault;
    } fetch_entry_t;

    // A PC is unusable when it is not word aligned or lies beyond the memory window.
    function automatic logic pc_is_bad(input logic [63:0] pc, input int unsigned max_bit);
        return (pc[1:0] != 2'b00) || ((pc >> (max_bit + 1)) != 64'd0);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is visible combinationally from storage.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head = mem_q[rd_ptr];

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr] <= din;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Upstream credit accounting must never push into a full buffer without a pop.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !flush && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction-fetch front end: PC sequencer, I-MEM request issue, credit-limited output buffer.
module imem_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned INST_WIDTH_LENGTH = 32,
    parameter int unsigned PC_WIDTH_LENGTH   = 32,
    parameter int unsigned MAX_MEM_DEPTH_BIT = 18,
    parameter logic [PC_WIDTH_LENGTH-1:0] RESET_PC = '0,
    parameter int unsigned FIFO_DEPTH        = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic                           mem_req,
    output logic [MAX_MEM_DEPTH_BIT-2:0]   mem_addr,
    input  logic [INST_WIDTH_LENGTH-1:0]   mem_rdata,
    input  logic                           redirect_valid,
    input  logic [PC_WIDTH_LENGTH-1:0]     redirect_pc,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [INST_WIDTH_LENGTH-1:0]   out_inst,
    output logic [PC_WIDTH_LENGTH-1:0]     out_pc,
    output logic                           out_fault
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CR_W    = CNT_W + 1;
    localparam int unsigned ENTRY_W = INST_WIDTH_LENGTH + PC_WIDTH_LENGTH + 1;

    logic [PC_WIDTH_LENGTH-1:0] fetch_pc;
    logic [PC_WIDTH_LENGTH-1:0] pending_pc;
    logic                       pending_fault;
    logic                       inflight;
    logic                       halted;

    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] push_data_c;
    logic [CR_W-1:0]    credit_c;
    logic               pop_c;
    logic               push_c;
    logic               issue_c;
    logic               pc_bad_c;

    assign pc_bad_c = pc_is_bad(64'(fetch_pc), MAX_MEM_DEPTH_BIT);
    assign pop_c    = out_valid && out_ready;
    // Slots already promised (buffered plus in flight) must leave room after this cycle's pop.
    assign credit_c = CR_W'(count) + CR_W'(inflight) - CR_W'(pop_c);
    assign issue_c  = !halted && !redirect_valid && (credit_c < CR_W'(FIFO_DEPTH));

    // Request is held low while reset is asserted, independent of the clock.
    assign mem_req  = rst_n && issue_c && !pc_bad_c;
    assign mem_addr = fetch_pc[MAX_MEM_DEPTH_BIT:2];

    assign push_c      = inflight && !redirect_valid;
    assign push_data_c = pending_fault ? {INST_WIDTH_LENGTH'(NOP_INST), pending_pc, 1'b1}
                                       : {mem_rdata, pending_pc, 1'b0};

    assign out_valid = (count != '0) && !redirect_valid;
    assign {out_inst, out_pc, out_fault} = head;

    // PC sequencer: redirect wins; a bad PC becomes a fault slot and stops fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc      <= RESET_PC;
            pending_pc    <= '0;
            pending_fault <= 1'b0;
            inflight      <= 1'b0;
            halted        <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            halted   <= 1'b0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue_c;
            if (issue_c) begin
                pending_pc    <= fetch_pc;
                pending_fault <= pc_bad_c;
                if (pc_bad_c) begin
                    halted <= 1'b1;
                end else begin
                    fetch_pc <= fetch_pc + PC_WIDTH_LENGTH'(4);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push_c),
        .pop   (pop_c),
        .din   (push_data_c),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit with a 1-cycle-latency memory returning 0x100 + word address.
module tb_imem_fetch_unit;

    localparam int unsigned IW   = 32;
    localparam int unsigned PW   = 32;
    localparam int unsigned MAXB = 18;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mem_req;
    logic [MAXB-2:0] mem_addr;
    logic [IW-1:0]   mem_rdata = '0;
    logic            redirect_valid = 1'b0;
    logic [PW-1:0]   redirect_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [IW-1:0]   out_inst;
    logic [PW-1:0]   out_pc;
    logic            out_fault;

    int n_checks = 0;
    int n_errors = 0;

    imem_fetch_unit #(
        .INST_WIDTH_LENGTH (IW),
        .PC_WIDTH_LENGTH   (PW),
        .MAX_MEM_DEPTH_BIT (MAXB),
        .RESET_PC          (32'h0),
        .FIFO_DEPTH        (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_fault      (out_fault)
    );

    always #5 clk = ~clk;

    // Synchronous I-MEM model.
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= 32'h100 + 32'(mem_addr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                              input logic fault);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".pc"},    64'(out_pc),    64'(pc));
        check({tag, ".inst"},  64'(out_inst),  64'(inst));
        check({tag, ".fault"}, 64'(out_fault), 64'(fault));
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        #1;
        check("redir.valid_low", 64'(out_valid), 64'd0);
        check("redir.req_low",   64'(mem_req),   64'd0);
        step();
        redirect_valid = 1'b0;
        #0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // Reset values.
        #1;
        check("rst.req",   64'(mem_req),   64'd0);
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.inst",  64'(out_inst),  64'd0);
        check("rst.pc",    64'(out_pc),    64'd0);
        check("rst.fault", 64'(out_fault), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;

        // Sequential fetch from reset with out_ready high.
        check("seq.req0",  64'(mem_req),  64'd1);
        check("seq.addr0", 64'(mem_addr), 64'd0);
        step();
        check("seq.valid1", 64'(out_valid), 64'd0);
        check("seq.addr1",  64'(mem_addr),  64'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("seq%0d", i), 32'(4 * i), 32'(32'h100 + i), 1'b0);
            check($sformatf("seq%0d.addr", i), 64'(mem_addr), 64'(i + 2));
            step();
        end

        // Backpressure: head 16 buffered with 20 in flight.
        out_ready = 1'b0;
        #1;
        check("bp.req_drop", 64'(mem_req), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out($sformatf("bp_hold%0d", i), 32'd16, 32'h104, 1'b0);
            check($sformatf("bp_hold%0d.req", i), 64'(mem_req), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.req_resume", 64'(mem_req),  64'd1);
        check("bp.addr",       64'(mem_addr), 64'd6);
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("drain%0d", i), 32'(16 + 4 * i), 32'(32'h104 + i), 1'b0);
            step();
        end

        // Redirect to 0x40 with a buffered entry and a response in flight.
        out_ready = 1'b0;
        do_redirect(32'h40);
        out_ready = 1'b1;
        #1;
        check("r40.req",   64'(mem_req),   64'd1);
        check("r40.addr",  64'(mem_addr),  64'h10);
        check("r40.valid", 64'(out_valid), 64'd0);
        step();
        check("r40.valid2", 64'(out_valid), 64'd0);
        step();
        expect_out("r40.e0", 32'h40, 32'h110, 1'b0);
        step();
        expect_out("r40.e1", 32'h44, 32'h111, 1'b0);

        // Misaligned redirect: one fault entry, then halt.
        do_redirect(32'h42);
        #1;
        check("r42.req", 64'(mem_req), 64'd0);
        step();
        check("r42.valid_pre", 64'(out_valid), 64'd0);
        step();
        expect_out("r42.fault", 32'h42, 32'h13, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("halt%0d.valid", i), 64'(out_valid), 64'd0);
            check($sformatf("halt%0d.req", i),   64'(mem_req),   64'd0);
        end
        do_redirect(32'h80);
        #1;
        check("r80.req",  64'(mem_req),  64'd1);
        check("r80.addr", 64'(mem_addr), 64'h20);
        step();
        step();
        expect_out("r80.e0", 32'h80, 32'h120, 1'b0);

        // Run off the end of the memory window.
        do_redirect(32'h7_FFFC);
        #1;
        check("top.req",  64'(mem_req),  64'd1);
        check("top.addr", 64'(mem_addr), 64'h1_FFFF);
        step();
        check("top.req_bad", 64'(mem_req), 64'd0);
        step();
        expect_out("top.last", 32'h7_FFFC, 32'h2_00FF, 1'b0);
        step();
        expect_out("top.fault", 32'h8_0000, 32'h13, 1'b1);
        step();
        check("top.valid_end", 64'(out_valid), 64'd0);
        check("top.req_end",   64'(mem_req),   64'd0);

        // Asynchronous reset mid-stream.
        do_redirect(32'h0);
        step();
        step();
        expect_out("pre_rst.e0", 32'h0, 32'h100, 1'b0);
        step();
        expect_out("pre_rst.e1", 32'h4, 32'h101, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid", 64'(out_valid), 64'd0);
        check("arst.req",   64'(mem_req),   64'd0);
        check("arst.pc",    64'(out_pc),    64'd0);
        check("arst.inst",  64'(out_inst),  64'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("rel.req",   64'(mem_req),   64'd1);
        check("rel.addr",  64'(mem_addr),  64'd0);
        check("rel.valid", 64'(out_valid), 64'd0);
        step();
        check("rel.valid1", 64'(out_valid), 64'd0);
        step();
        expect_out("rel.e0", 32'h0, 32'h100, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
